// File: rtl/hilo_muldiv.sv
// ----------------------------------------------------------------------------
// hilo_muldiv
//
// Iterative multiply/divide unit holding the architectural HI/LO registers of
// the MIPS core. Handles MULT, MULTU, DIV, DIVU (32 iterations, one bit per
// cycle) and the single-cycle MTHI/MTLO moves. Sits in the execute stage; the
// core stalls on busy and reads hi/lo through the MFHI/MFLO writeback mux.
//
// Ports
//   clk        in   1   clock, all state updates on the rising edge
//   reset      in   1   synchronous active-high reset
//   start      in   1   request strobe, sampled on the rising edge
//   op         in   3   000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                       100 MTHI, 101 MTLO, 110/111 reserved (ignored)
//   operand_a  in  32   rs: multiplicand / dividend / MTHI-MTLO source
//   operand_b  in  32   rt: multiplier / divisor
//   busy       out  1   operation in flight (state != IDLE), registered
//   done       out  1   one-cycle pulse, hi/lo hold the new result
//   hi         out 32   HI register
//   lo         out 32   LO register
//
// Latency: accept at E0, iterations on E1..E32, result written at E33 with
// done high in the following cycle. A new request may be sampled at E34.
// ----------------------------------------------------------------------------
module hilo_muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t      state_q;
  logic [4:0]  count_q;
  logic        is_div_q;
  logic        sign_a_q;
  logic        sign_b_q;
  logic [31:0] a_mag_q;
  logic [31:0] b_mag_q;
  logic [63:0] acc_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;

  // --------------------------------------------------------------------------
  // Operand capture: signed ops (even op codes) work on magnitudes and keep the
  // signs for the final correction; unsigned ops use the raw values.
  // --------------------------------------------------------------------------
  logic        op_signed;
  logic        sign_a_d;
  logic        sign_b_d;
  logic [31:0] a_mag_d;
  logic [31:0] b_mag_d;

  always_comb begin
    op_signed = ~op[0];
    sign_a_d  = op_signed & operand_a[31];
    sign_b_d  = op_signed & operand_b[31];
    a_mag_d   = sign_a_d ? (32'd0 - operand_a) : operand_a;
    b_mag_d   = sign_b_d ? (32'd0 - operand_b) : operand_b;
  end

  // --------------------------------------------------------------------------
  // One iteration, MSB first; count_q selects the operand bit in use.
  //   Multiply: acc = 2*acc + (b[count] ? a : 0)
  //   Divide:   acc[63:32] is the partial remainder, acc[31:0] collects the
  //             quotient bits shifted in from the right.
  // --------------------------------------------------------------------------
  logic [63:0] acc_d;
  logic [32:0] rem_shift;
  logic [32:0] rem_diff;
  logic        rem_ge;

  always_comb begin
    acc_d     = acc_q;
    rem_shift = {acc_q[63:32], a_mag_q[count_q]};
    rem_diff  = rem_shift - {1'b0, b_mag_q};
    // Explicit compare rather than the borrow bit: with a zero divisor the
    // shifted remainder can reach bit 32 and must still count as ">=".
    rem_ge    = (rem_shift >= {1'b0, b_mag_q});
    if (is_div_q) begin
      if (rem_ge) begin
        acc_d = {rem_diff[31:0], acc_q[30:0], 1'b1};
      end else begin
        acc_d = {rem_shift[31:0], acc_q[30:0], 1'b0};
      end
    end else begin
      acc_d = {acc_q[62:0], 1'b0} +
              (b_mag_q[count_q] ? {32'd0, a_mag_q} : 64'd0);
    end
  end

  // --------------------------------------------------------------------------
  // Sign correction applied in FIX.
  //   Multiply: negate the 64-bit product if the operand signs differ.
  //   Divide:   quotient negated if signs differ, remainder follows the
  //             dividend. A zero divisor forces the quotient to all ones; the
  //             remainder path already reproduces the dividend in that case.
  //             0x80000000 / -1 yields 0x80000000 from the magnitude math.
  // --------------------------------------------------------------------------
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic        div_zero;
  logic [31:0] fix_hi_d;
  logic [31:0] fix_lo_d;

  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? (64'd0 - acc_q) : acc_q;
    quo_fix  = (sign_a_q ^ sign_b_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    rem_fix  = sign_a_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    div_zero = (b_mag_q == 32'd0);
    if (is_div_q) begin
      fix_hi_d = rem_fix;
      fix_lo_d = div_zero ? 32'hFFFF_FFFF : quo_fix;
    end else begin
      fix_hi_d = prod_fix[63:32];
      fix_lo_d = prod_fix[31:0];
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered busy/done.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= 5'd0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_mag_q  <= 32'd0;
      b_mag_q  <= 32'd0;
      acc_q    <= 64'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (!op[2]) begin
              is_div_q <= op[1];
              sign_a_q <= sign_a_d;
              sign_b_q <= sign_b_d;
              a_mag_q  <= a_mag_d;
              b_mag_q  <= b_mag_d;
              acc_q    <= 64'd0;
              count_q  <= 5'd31;
              busy_q   <= 1'b1;
              state_q  <= ST_RUN;
            end else if (op == OP_MTHI) begin
              hi_q <= operand_a;
            end else if (op == OP_MTLO) begin
              lo_q <= operand_a;
            end
          end
        end

        ST_RUN: begin
          acc_q <= acc_d;
          if (count_q == 5'd0) begin
            state_q <= ST_FIX;
          end else begin
            count_q <= count_q - 5'd1;
          end
        end

        ST_FIX: begin
          hi_q    <= fix_hi_d;
          lo_q    <= fix_lo_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// ----------------------------------------------------------------------------
// tb_hilo_muldiv
//
// Self-checking bench for hilo_muldiv: directed cases from the block's test
// plan followed by randomized requests, all compared against a plain
// arithmetic reference model of the HI/LO registers.
// ----------------------------------------------------------------------------
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_errors = 0;

  // Model of the architectural registers
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  hilo_muldiv dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result {hi, lo} for the mul/div ops using native arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] f_op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur, res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    res = 64'd0;
    case (f_op)
      3'b000: begin
        sq  = sa * sb;
        res = 64'(sq);
      end
      3'b001: res = ua * ub;
      3'b010: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          sq  = sa / sb;
          sr  = sa % sb;
          res = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          uq  = ua / ub;
          ur  = ua % ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = 32'd1;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issue one mul/div op, follow it to done and check timing and result.
  // With disturb set, operands change and MTLO/MULT/MTHI requests are
  // presented while the unit is busy; none of them may have any effect.
  task automatic run_muldiv(input logic [2:0] f_op, input logic [31:0] a,
                            input logic [31:0] b, input bit disturb);
    logic [63:0] exp;
    int          busy_cnt;
    bit          done_seen;
    exp = ref_result(f_op, a, b);
    @(negedge clk);
    start = 1'b1; op = f_op; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0;
    busy_cnt  = 0;
    done_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        done_seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      if (c == 16) begin
        check_val("hold_hi", 64'(hi), 64'(m_hi));
        check_val("hold_lo", 64'(lo), 64'(m_lo));
      end
      if (disturb) begin
        case (c)
          3:  begin operand_a = $urandom; operand_b = $urandom; end
          6:  begin start = 1'b1; op = 3'b101; end
          7:  start = 1'b0;
          10: begin start = 1'b1; op = 3'b000; operand_a = $urandom; end
          11: start = 1'b0;
          31: begin start = 1'b1; op = 3'b100; operand_a = $urandom; end
          32: start = 1'b0;
          default: ;
        endcase
      end
      @(negedge clk);
    end
    check_val("done_seen", 64'(done_seen), 64'd1);
    check_val("busy_cycles", 64'(busy_cnt), 64'd33);
    check_val("busy_at_done", 64'(busy), 64'd0);
    check_val("result_hi", 64'(hi), 64'(exp[63:32]));
    check_val("result_lo", 64'(lo), 64'(exp[31:0]));
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    $display("op=%0d a=%08h b=%08h disturb=%0d -> hi=%08h lo=%08h", f_op, a, b, disturb, hi, lo);
    @(negedge clk);
    check_val("done_pulse", 64'(done), 64'd0);
  endtask

  // MTHI / MTLO / reserved ops: one request, checked on the next cycle.
  task automatic run_move(input logic [2:0] f_op, input logic [31:0] a);
    @(negedge clk);
    start = 1'b1; op = f_op; operand_a = a; operand_b = $urandom;
    @(negedge clk);
    start = 1'b0;
    if (f_op == 3'b100) m_hi = a;
    if (f_op == 3'b101) m_lo = a;
    check_val("move_hi", 64'(hi), 64'(m_hi));
    check_val("move_lo", 64'(lo), 64'(m_lo));
    check_val("move_busy", 64'(busy), 64'd0);
    check_val("move_done", 64'(done), 64'd0);
    $display("op=%0d a=%08h -> hi=%08h lo=%08h", f_op, a, hi, lo);
  endtask

  // MULTU 5x6 aborted by reset sampled at E10.
  task automatic run_abort();
    bit done_seen;
    @(negedge clk);
    start = 1'b1; op = 3'b001; operand_a = 32'd5; operand_b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    check_val("abort_busy", 64'(busy), 64'd0);
    check_val("abort_done", 64'(done), 64'd0);
    check_val("abort_hi", 64'(hi), 64'd0);
    check_val("abort_lo", 64'(lo), 64'd0);
    done_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done) done_seen = 1'b1;
      @(negedge clk);
    end
    check_val("abort_no_done", 64'(done_seen), 64'd0);
    $display("abort: MULTU 5x6 reset at E10 -> hi=%08h lo=%08h busy=%0d", hi, lo, busy);
  endtask

  initial begin
    logic [2:0] r_op;
    reset     = 1'b1;
    start     = 1'b0;
    op        = 3'b000;
    operand_a = 32'd0;
    operand_b = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("reset_hi", 64'(hi), 64'd0);
    check_val("reset_lo", 64'(lo), 64'd0);
    check_val("reset_busy", 64'(busy), 64'd0);
    check_val("reset_done", 64'(done), 64'd0);

    // Directed cases
    run_muldiv(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_muldiv(3'b000, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_muldiv(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_muldiv(3'b011, 32'd100, 32'd0, 1'b0);
    run_muldiv(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_muldiv(3'b010, 32'hFFFF_FFF9, 32'd0, 1'b0);
    run_move(3'b100, 32'h1234_5678);
    run_move(3'b101, 32'h8765_4321);
    run_move(3'b110, 32'hDEAD_BEEF);
    run_move(3'b111, 32'hCAFE_F00D);
    run_muldiv(3'b010, 32'd1000, 32'hFFFF_FFF9, 1'b1);
    run_muldiv(3'b000, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    run_abort();
    run_muldiv(3'b001, 32'd5, 32'd6, 1'b0);

    // Randomized requests
    for (int i = 0; i < 60; i++) begin
      r_op = 3'($urandom_range(0, 7));
      if (!r_op[2]) begin
        run_muldiv(r_op, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
      end else begin
        run_move(r_op, $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Iterative multiply/divide unit with architectural HI/LO registers. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO for the MIPS core, and sits in the execute stage directly downstream of the register file. Its operands come from the two register-file read ports (rs, rt). Its HI/LO outputs feed the MFHI/MFLO writeback mux, whose result returns to the register file write port. `busy` stalls the core while an operation is in flight.

## Interface
- No parameters; datapath width fixed at 32 bits.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled on rising edge.
- op  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved.
- operand_a  in  32  rs value (multiplicand / dividend / MTHI-MTLO source).
- operand_b  in  32  rt value (multiplier / divisor).
- busy  out  1  operation in flight; core must not issue, and must not read HI/LO.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE with start=1:
  - op 000–011: capture op, operand signs, |a| and |b| (unsigned ops use raw values), clear the 64-bit accumulator, load count=31, then go to RUN.
  - op 100: hi <= operand_a; stay in IDLE; done stays 0.
  - op 101: lo <= operand_a; stay in IDLE; done stays 0.
  - op 110/111: ignored; no state change.
- RUN: one iteration per cycle.
  - Multiply: shift-add, one multiplier bit per cycle.
  - Divide: restoring, one quotient bit per cycle.
  - When count reaches 0, go to FIX; otherwise decrement count.
- FIX: apply sign correction, write hi/lo, pulse done, return to IDLE.
- Multiply result: 64-bit product; {hi,lo} = product.
  - MULT negates the magnitude product if sign_a XOR sign_b.
- Divide result: lo = quotient, hi = remainder.
  - DIV quotient is negated if sign_a XOR sign_b.
  - DIV remainder takes the sign of the dividend (truncating division).
- Divide by zero (DIV or DIVU, operand_b=0): lo=0xFFFFFFFF, hi=operand_a. Latency is still the full latency.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of unsigned magnitude arithmetic; no special case is needed.
- start while busy=1 is ignored, including MTHI/MTLO.
- Operands are captured at acceptance; later changes to operand_a/operand_b have no effect.
- hi/lo change only at the FIX→IDLE edge, on MTHI/MTLO, or on reset. During RUN they hold their previous values.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, count=0.
- Reset asserted in any state aborts the operation on that edge; no partial result is written.
- Reset has priority over start.
- Mul/div acceptance edge is E0.
- Edges E1–E32 perform iterations 31 down to 0. State is RUN from E0 through E32.
- The E32 edge enters FIX.
- The E33 edge writes hi/lo, sets done=1, and returns to IDLE.
- busy = (state != IDLE). It is high for exactly 33 cycles: the cycles following E0 through E32.
- done is high for exactly one cycle, following E33, alongside the new hi/lo. busy=0 in that cycle.
- A new start may be sampled at E34 (the cycle in which done=1), giving back-to-back throughput of one op per 34 cycles.
- MTHI/MTLO: value visible on hi/lo in the cycle after the sampling edge; busy never asserts.
- done and busy are registered outputs; no combinational path from inputs.

## Test plan
- Reset, then MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → busy high 33 cycles; done pulse one cycle; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- Divide-by-zero and overflow:
  - DIVU a=100, b=0 → lo=0xFFFFFFFF, hi=100 after the full 34-cycle latency.
  - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Ignored requests:
  - MTHI a=0x12345678 while idle → hi=0x12345678 next cycle; busy stays 0.
  - MTLO or MULT issued mid-RUN → ignored; in-flight result unaffected.
  - Operand changes during RUN → no effect on the result.
- Start MULTU 5×6, assert reset at E10 → busy=0, done never pulses, hi=lo=0.
  - A subsequent MULTU 5×6 yields lo=30, hi=0.
